// File: rtl/voice_audio_pkg.sv
// Shared types, defaults and helpers for the voice audio conditioning stage.
package voice_audio_pkg;

  localparam int unsigned DefInW        = 16;
  localparam int unsigned DefDcShift    = 8;
  localparam int unsigned DefInterpLog2 = 8;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StRamp,
    StHold
  } state_e;

  // Clamp a signed value to the range of a signed `width`-bit number (width <= 31).
  function automatic logic signed [31:0] sat_s(input logic signed [31:0] value,
                                               input int unsigned        width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic signed [31:0] res;
    hi = (32'sd1 <<< (width - 32'd1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (value > hi) begin
      res = hi;
    end else if (value < lo) begin
      res = lo;
    end else begin
      res = value;
    end
    return res;
  endfunction

endpackage

// File: rtl/voice_audio_cond_if.sv
// Sample-in / DAC-out bundle between the synthesiser and the conditioning stage.
interface voice_audio_cond_if
  import voice_audio_pkg::*;
#(
  parameter int unsigned IN_W = DefInW
);

  logic signed [IN_W-1:0] sample_i;
  logic                   sample_stb_i;
  logic                   mute_i;
  logic signed [IN_W-1:0] dac_o;
  logic                   busy_o;
  logic                   overrun_o;

  modport master (
    output sample_i, sample_stb_i, mute_i,
    input  dac_o, busy_o, overrun_o
  );

  modport slave (
    input  sample_i, sample_stb_i, mute_i,
    output dac_o, busy_o, overrun_o
  );

endinterface

// File: rtl/voice_dc_block.sv
// Leaky-integrator DC blocker: y = x - (d >>> DC_SHIFT); d accumulates y when enabled.
module voice_dc_block
  import voice_audio_pkg::*;
#(
  parameter int unsigned IN_W     = DefInW,
  parameter int unsigned DC_SHIFT = DefDcShift
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   en_i,
  input  logic signed [IN_W-1:0] x_i,
  output logic signed [IN_W+1:0] y_o
);

  // d tracks x scaled by 2^DC_SHIFT; one spare bit keeps the update from wrapping.
  localparam int unsigned DW = IN_W + DC_SHIFT + 1;

  logic signed [DW-1:0] d_q, d_d;
  logic signed [DW-1:0] est;
  logic signed [DW-1:0] y_full;

  assign est    = d_q >>> DC_SHIFT;
  assign y_full = DW'(x_i) - est;
  // est spans IN_W+1 bits, so the difference always fits in IN_W+2 bits.
  assign y_o    = y_full[IN_W+1:0];

  // Next estimate: fold the unsaturated output back in only when a sample is processed.
  always_comb begin
    d_d = d_q;
    if (en_i) begin
      d_d = d_q + y_full;
    end
  end

  // Estimator register with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      d_q <= '0;
    end else begin
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/voice_audio_cond.sv
// Audio conditioning: optional DC blocking, then a linear ramp from the current DAC
// value to the new target over 2^INTERP_LOG2 clocks. Sticky overrun on CALC collisions.
module voice_audio_cond
  import voice_audio_pkg::*;
#(
  parameter int unsigned IN_W        = DefInW,
  parameter bit          DC_EN       = 1'b1,
  parameter int unsigned DC_SHIFT    = DefDcShift,
  parameter int unsigned INTERP_LOG2 = DefInterpLog2
) (
  input logic               clock_i,
  input logic               reset_i,
  voice_audio_cond_if.slave bus
);

  localparam int unsigned YW     = IN_W + 2;
  localparam int unsigned DeltaW = IN_W + 1;
  localparam int unsigned AccW   = IN_W + INTERP_LOG2 + 1;
  localparam int unsigned CntW   = INTERP_LOG2 + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'((32'd1 << INTERP_LOG2) - 32'd1);

  state_e                   state_q, state_d;
  logic signed [IN_W-1:0]   x_q, x_d;
  logic signed [IN_W-1:0]   dac_q, dac_d;
  logic signed [DeltaW-1:0] delta_q, delta_d;
  logic signed [AccW-1:0]   acc_q, acc_d;
  logic signed [AccW-1:0]   acc_sum;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  logic                     ovr_q, ovr_d;

  logic signed [YW-1:0]     y_raw;
  logic signed [IN_W-1:0]   y_sat;
  logic signed [IN_W-1:0]   target;
  logic                     calc_en;

  // The estimator advances on every CALC edge, including one cut short by a newer sample.
  assign calc_en = (state_q == StCalc);

  if (DC_EN) begin : g_dc
    voice_dc_block #(
      .IN_W     (IN_W),
      .DC_SHIFT (DC_SHIFT)
    ) u_dc_block (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .en_i    (calc_en),
      .x_i     (x_q),
      .y_o     (y_raw)
    );
  end else begin : g_no_dc
    assign y_raw = YW'(x_q);
  end

  assign y_sat   = IN_W'(sat_s(32'(y_raw), IN_W));
  assign target  = bus.mute_i ? '0 : y_sat;
  assign acc_sum = acc_q + AccW'(delta_q);

  // Next-state and datapath: a strobe always wins over a ramp step.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    dac_d   = dac_q;
    delta_d = delta_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      StIdle, StHold: begin
        if (bus.sample_stb_i) begin
          x_d     = bus.sample_i;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (bus.sample_stb_i) begin
          x_d   = bus.sample_i;
          ovr_d = 1'b1;
        end else begin
          delta_d = DeltaW'(target) - DeltaW'(dac_q);
          // Restart from the integer DAC value; any fractional residue is dropped.
          acc_d   = AccW'(dac_q) <<< INTERP_LOG2;
          cnt_d   = '0;
          state_d = StRamp;
        end
      end
      StRamp: begin
        if (bus.sample_stb_i) begin
          x_d     = bus.sample_i;
          state_d = StCalc;
        end else begin
          acc_d = acc_sum;
          dac_d = IN_W'(acc_sum >>> INTERP_LOG2);
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d = StHold;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StCalc) || (state_d == StRamp);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      x_q     <= '0;
      dac_q   <= '0;
      delta_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      dac_q   <= dac_d;
      delta_q <= delta_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.dac_o     = dac_q;
  assign bus.busy_o    = busy_q;
  assign bus.overrun_o = ovr_q;

endmodule

// File: tb/tb_voice_audio_cond.sv
// Bench for voice_audio_cond: three parameterisations, directed steps then random traffic,
// every cycle compared against an arithmetic model of ramps and the DC estimator.
module tb_voice_audio_cond;

  logic clk;
  logic rst_a, rst_b, rst_c;

  voice_audio_cond_if #(.IN_W(16)) ifa ();
  voice_audio_cond_if #(.IN_W(16)) ifb ();
  voice_audio_cond_if #(.IN_W(16)) ifc ();

  voice_audio_cond #(.IN_W(16), .DC_EN(1'b0), .DC_SHIFT(8), .INTERP_LOG2(2)) dut_a (
    .clock_i (clk),
    .reset_i (rst_a),
    .bus     (ifa)
  );
  voice_audio_cond #(.IN_W(16), .DC_EN(1'b1), .DC_SHIFT(4), .INTERP_LOG2(0)) dut_b (
    .clock_i (clk),
    .reset_i (rst_b),
    .bus     (ifb)
  );
  voice_audio_cond #(.IN_W(16), .DC_EN(1'b1), .DC_SHIFT(8), .INTERP_LOG2(8)) dut_c (
    .clock_i (clk),
    .reset_i (rst_c),
    .bus     (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Per-unit parameters as seen by the model.
  int p_dc [3] = '{0, 1, 1};
  int p_sh [3] = '{8, 4, 8};
  int p_l2 [3] = '{2, 0, 8};

  // Stimulus currently applied to each unit.
  bit     cur_rst  [3];
  bit     cur_stb  [3];
  longint cur_smp  [3];
  bit     cur_mute [3];

  // Model: phase 0 = quiet, 1 = computing, 2 = ramping.
  int     m_phase [3];
  longint m_x [3], m_d [3], m_start [3], m_delta [3], m_k [3], m_dac [3];
  bit     m_busy [3], m_ovr [3];

  int errors = 0;
  int checks = 0;

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] dac_of(input int u);
    logic signed [63:0] v;
    case (u)
      0:       v = ifa.dac_o;
      1:       v = ifb.dac_o;
      default: v = ifc.dac_o;
    endcase
    return v;
  endfunction

  function automatic logic busy_of(input int u);
    case (u)
      0:       return ifa.busy_o;
      1:       return ifb.busy_o;
      default: return ifc.busy_o;
    endcase
  endfunction

  function automatic logic ovr_of(input int u);
    case (u)
      0:       return ifa.overrun_o;
      1:       return ifb.overrun_o;
      default: return ifc.overrun_o;
    endcase
  endfunction

  task automatic apply();
    rst_a = cur_rst[0]; ifa.sample_stb_i = cur_stb[0];
    ifa.sample_i = 16'(cur_smp[0]); ifa.mute_i = cur_mute[0];
    rst_b = cur_rst[1]; ifb.sample_stb_i = cur_stb[1];
    ifb.sample_i = 16'(cur_smp[1]); ifb.mute_i = cur_mute[1];
    rst_c = cur_rst[2]; ifc.sample_stb_i = cur_stb[2];
    ifc.sample_i = 16'(cur_smp[2]); ifc.mute_i = cur_mute[2];
  endtask

  task automatic mstep(input int u);
    longint y, tgt, n;
    n = longint'(1) << p_l2[u];
    if (cur_rst[u]) begin
      m_phase[u] = 0; m_x[u] = 0; m_d[u] = 0; m_dac[u] = 0;
      m_start[u] = 0; m_delta[u] = 0; m_k[u] = 0; m_ovr[u] = 0;
    end else begin
      case (m_phase[u])
        0: if (cur_stb[u]) begin m_x[u] = cur_smp[u]; m_phase[u] = 1; end
        1: begin
          if (p_dc[u] != 0) begin
            y = m_x[u] - floor_div(m_d[u], longint'(1) << p_sh[u]);
            m_d[u] = m_d[u] + y;
          end else begin
            y = m_x[u];
          end
          if (y > 32767) y = 32767;
          if (y < -32768) y = -32768;
          tgt = cur_mute[u] ? 0 : y;
          if (cur_stb[u]) begin
            m_x[u] = cur_smp[u];
            m_ovr[u] = 1;
          end else begin
            m_start[u] = m_dac[u];
            m_delta[u] = tgt - m_dac[u];
            m_k[u] = 0;
            m_phase[u] = 2;
          end
        end
        default: begin
          if (cur_stb[u]) begin
            m_x[u] = cur_smp[u];
            m_phase[u] = 1;
          end else begin
            m_k[u] = m_k[u] + 1;
            m_dac[u] = m_start[u] + floor_div(m_k[u] * m_delta[u], n);
            if (m_k[u] == n) m_phase[u] = 0;
          end
        end
      endcase
    end
    m_busy[u] = (m_phase[u] != 0);
  endtask

  // One clock: drive, let the edge happen, advance the model, compare on the falling edge.
  task automatic tick();
    apply();
    @(posedge clk);
    for (int u = 0; u < 3; u++) mstep(u);
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("u%0d_dac", u), dac_of(u), m_dac[u]);
      chk($sformatf("u%0d_busy", u), {63'd0, busy_of(u)}, longint'(m_busy[u]));
      chk($sformatf("u%0d_overrun", u), {63'd0, ovr_of(u)}, longint'(m_ovr[u]));
    end
  endtask

  task automatic strobe(input int u, input longint v);
    cur_stb[u] = 1'b1;
    cur_smp[u] = v;
    tick();
    cur_stb[u] = 1'b0;
  endtask

  initial begin
    logic signed [63:0] prev;
    for (int u = 0; u < 3; u++) begin
      cur_rst[u] = 1'b1; cur_stb[u] = 1'b0; cur_smp[u] = 0; cur_mute[u] = 1'b0;
    end
    apply();
    repeat (2) @(posedge clk);
    @(negedge clk);
    tick();
    for (int u = 0; u < 3; u++) cur_rst[u] = 1'b0;
    tick();
    chk("reset_dac", dac_of(0), 0);
    chk("reset_busy", {63'd0, busy_of(0)}, 0);
    chk("reset_overrun", {63'd0, ovr_of(2)}, 0);

    // Plain ramp 0 -> 1000 in four steps.
    strobe(0, 1000);
    chk("t1_e0_busy", {63'd0, busy_of(0)}, 1);
    tick();
    tick(); chk("t1_e2", dac_of(0), 250);
    tick(); chk("t1_e3", dac_of(0), 500);
    tick(); chk("t1_e4", dac_of(0), 750);
    tick(); chk("t1_e5", dac_of(0), 1000);
    chk("t1_done_busy", {63'd0, busy_of(0)}, 0);

    // Restart mid-ramp from 500 towards -400.
    cur_rst[0] = 1'b1; tick(); cur_rst[0] = 1'b0;
    strobe(0, 1000); tick(); tick();
    tick(); chk("t4_at500", dac_of(0), 500);
    strobe(0, -400); chk("t4_hold500", dac_of(0), 500);
    chk("t4_busy", {63'd0, busy_of(0)}, 1);
    tick(); chk("t4_calc500", dac_of(0), 500);
    tick(); chk("t4_s1", dac_of(0), 275);
    tick(); chk("t4_s2", dac_of(0), 50);
    tick(); chk("t4_s3", dac_of(0), -175);
    tick(); chk("t4_s4", dac_of(0), -400);

    // Back-to-back strobes: overrun, second sample wins.
    cur_stb[0] = 1'b1; cur_smp[0] = 111; tick();
    cur_smp[0] = 2000; tick(); cur_stb[0] = 1'b0;
    chk("t5_overrun", {63'd0, ovr_of(0)}, 1);
    tick();
    tick(); chk("t5_s1", dac_of(0), 200);
    repeat (3) tick();
    chk("t5_target", dac_of(0), 2000);
    cur_mute[0] = 1'b1; strobe(0, 12000); tick(); cur_mute[0] = 1'b0;
    repeat (4) tick();
    chk("t5_muted", dac_of(0), 0);
    chk("t5_sticky", {63'd0, ovr_of(0)}, 1);

    // Reset in the middle of a ramp.
    strobe(0, 1000); tick(); tick();
    cur_rst[0] = 1'b1; tick(); cur_rst[0] = 1'b0;
    chk("t6_dac", dac_of(0), 0);
    chk("t6_busy", {63'd0, busy_of(0)}, 0);
    chk("t6_overrun", {63'd0, ovr_of(0)}, 0);
    strobe(1, 100); tick(); tick();
    chk("t6_single_step", dac_of(1), 100);
    cur_rst[1] = 1'b1; tick(); cur_rst[1] = 1'b0; tick();

    // DC blocker decay on a constant input.
    prev = 64'sd32767;
    for (int i = 0; i < 200; i++) begin
      strobe(1, 8000); tick(); tick();
      if (i == 0) chk("t2_first", dac_of(1), 8000);
      if (i == 1) chk("t2_second", dac_of(1), 7500);
      if (i == 2) chk("t2_third", dac_of(1), 7032);
      chk("t2_monotonic", {63'd0, dac_of(1) <= prev}, 1);
      prev = dac_of(1);
      tick();
    end
    chk("t2_settled", {63'd0, (dac_of(1) < 16) && (dac_of(1) > -16)}, 1);

    // Saturation after priming the estimator high.
    for (int i = 0; i < 200; i++) begin
      strobe(1, 30000); repeat (3) tick();
    end
    strobe(1, -32768); tick(); tick();
    chk("t3_saturated", dac_of(1), -32768);

    // Random traffic on all units.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int u = 0; u < 3; u++) begin
        int den;
        den = (u == 0) ? 6 : ((u == 1) ? 5 : 300);
        cur_stb[u]  = ($urandom_range(0, den - 1) == 0);
        cur_mute[u] = ($urandom_range(0, 7) == 0);
        cur_rst[u]  = ($urandom_range(0, 999) == 0);
        case ($urandom_range(0, 7))
          0:       cur_smp[u] = 32767;
          1:       cur_smp[u] = -32768;
          default: cur_smp[u] = longint'($urandom_range(0, 65535)) - 32768;
        endcase
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
